// File: rtl/hazard_pkg.sv
`default_nettype none
//==============================================================================
// Module      : hazard_pkg
// Description : Shared types and forward-source encodings for hazard_fwd_unit.
// Revision    : 1.0 - initial release
//==============================================================================
package hazard_pkg;

  // Widest register address a slot can record; REG_AW must not exceed this.
  localparam int SLOT_DW    = 8;
  localparam int FWD_SRC_RF = 0;

  typedef struct packed {
    logic               valid;
    logic               wr;
    logic               ld;
    logic [SLOT_DW-1:0] dest;
  } slot_t;

  function automatic int fwd_src_mem(input int k);
    return k;
  endfunction

  function automatic int fwd_src_wb(input int mem_stages);
    return mem_stages + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_src_find.sv
`default_nettype none
//==============================================================================
// Module      : fwd_src_find
// Description : Youngest-producer priority finder for one source register.
// Revision    : 1.0 - initial release
//==============================================================================
module fwd_src_find
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int NSLOT  = 2,
  parameter int JW     = 2
) (
  input  slot_t             slots [NSLOT],
  input  logic [REG_AW-1:0] src,
  input  logic              src_used,
  output logic              hit,
  output logic [JW-1:0]     j,
  output logic              is_load
);

  // Scan oldest to youngest so the lowest matching index wins.
  always_comb begin
    hit     = 1'b0;
    j       = '0;
    is_load = 1'b0;
    if (src_used && (src != '0)) begin
      for (int i = NSLOT - 1; i >= 0; i--) begin
        if (slots[i].valid && slots[i].wr && (slots[i].dest == SLOT_DW'(src))) begin
          hit     = 1'b1;
          j       = JW'(i);
          is_load = slots[i].ld;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_fwd_unit.sv
`default_nettype none
//==============================================================================
// Module      : hazard_fwd_unit
// Description : ID-stage stall detection and registered EX forwarding selects.
// Revision    : 1.0 - initial release
//==============================================================================
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int MEM_STAGES = 1,
  parameter int FWD_EN     = 1,
  parameter int CNT_W      = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              id_valid,
  input  logic [REG_AW-1:0]                 id_rs,
  input  logic [REG_AW-1:0]                 id_rt,
  input  logic                              id_use_rs,
  input  logic                              id_use_rt,
  input  logic                              id_reg_write,
  input  logic                              id_mem_read,
  input  logic [REG_AW-1:0]                 id_dest,
  input  logic                              id_flush,
  output logic                              stall,
  output logic                              ex_valid,
  output logic [$clog2(MEM_STAGES+2)-1:0]   ex_fwd_a_sel,
  output logic [$clog2(MEM_STAGES+2)-1:0]   ex_fwd_b_sel,
  output logic [CNT_W-1:0]                  stall_cnt
);

  localparam int c_SW    = $clog2(MEM_STAGES + 2);
  localparam int c_NSLOT = MEM_STAGES + 2;
  localparam int c_NSRCH = MEM_STAGES + 1;

  slot_t             r_slot [c_NSLOT];
  slot_t             w_srch [c_NSRCH];
  logic [c_SW-1:0]   r_sel_a, r_sel_b;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_hit_a, w_hit_b, w_ld_a, w_ld_b;
  logic [c_SW-1:0]   w_j_a, w_j_b;
  logic              w_haz_a, w_haz_b, w_adv;
  logic [c_SW-1:0]   w_sel_a, w_sel_b;

  // The WB slot is excluded: the register file bypasses its own write.
  for (genvar gi = 0; gi < c_NSRCH; gi++) begin : g_srch
    assign w_srch[gi] = r_slot[gi];
  end

  fwd_src_find #(.REG_AW(REG_AW), .NSLOT(c_NSRCH), .JW(c_SW)) u_find_rs (
    .slots    (w_srch),
    .src      (id_rs),
    .src_used (id_use_rs),
    .hit      (w_hit_a),
    .j        (w_j_a),
    .is_load  (w_ld_a)
  );

  fwd_src_find #(.REG_AW(REG_AW), .NSLOT(c_NSRCH), .JW(c_SW)) u_find_rt (
    .slots    (w_srch),
    .src      (id_rt),
    .src_used (id_use_rt),
    .hit      (w_hit_b),
    .j        (w_j_b),
    .is_load  (w_ld_b)
  );

  if (FWD_EN != 0) begin : g_fwd
    // Load data exists only once the load has left the last memory stage.
    assign w_haz_a = w_hit_a & w_ld_a & (w_j_a < c_SW'(MEM_STAGES));
    assign w_haz_b = w_hit_b & w_ld_b & (w_j_b < c_SW'(MEM_STAGES));
    assign w_sel_a = !w_hit_a ? c_SW'(FWD_SRC_RF)
                   : (w_j_a == c_SW'(MEM_STAGES)) ? c_SW'(fwd_src_wb(MEM_STAGES))
                   : c_SW'(fwd_src_mem(int'(w_j_a) + 1));
    assign w_sel_b = !w_hit_b ? c_SW'(FWD_SRC_RF)
                   : (w_j_b == c_SW'(MEM_STAGES)) ? c_SW'(fwd_src_wb(MEM_STAGES))
                   : c_SW'(fwd_src_mem(int'(w_j_b) + 1));
  end else begin : g_nofwd
    assign w_haz_a = w_hit_a;
    assign w_haz_b = w_hit_b;
    assign w_sel_a = c_SW'(FWD_SRC_RF);
    assign w_sel_b = c_SW'(FWD_SRC_RF);
  end

  assign stall = id_valid & ~id_flush & (w_haz_a | w_haz_b);
  assign w_adv = ~stall & ~id_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < c_NSLOT; i++) begin
        r_slot[i] <= '0;
      end
      r_sel_a <= '0;
      r_sel_b <= '0;
      r_cnt   <= '0;
    end else begin
      r_slot[0] <= '{valid: id_valid & w_adv,
                     wr:    id_reg_write,
                     ld:    id_mem_read,
                     dest:  SLOT_DW'(id_dest)};
      for (int i = 1; i < c_NSLOT; i++) begin
        r_slot[i] <= r_slot[i-1];
      end
      r_sel_a <= w_adv ? w_sel_a : '0;
      r_sel_b <= w_adv ? w_sel_b : '0;
      if (stall && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign ex_valid     = r_slot[0].valid;
  assign ex_fwd_a_sel = r_sel_a;
  assign ex_fwd_b_sel = r_sel_b;
  assign stall_cnt    = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_fwd_unit.sv
`default_nettype none
//==============================================================================
// Module      : tb_hazard_fwd_unit
// Description : Directed scoreboard bench over four hazard_fwd_unit configs.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_hazard_fwd_unit;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic       rw;
    logic       mr;
    logic [4:0] dest;
    logic       flush;
  } id_t;

  typedef struct {
    int          d;
    logic        stall;
    logic        exv;
    logic [1:0]  a;
    logic [1:0]  b;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  id_t         id_in     [4];
  logic        stall_o   [4];
  logic        exv_o     [4];
  logic [1:0]  sel_a_o   [4];
  logic [1:0]  sel_b_o   [4];
  logic [31:0] cnt_o     [4];
  exp_t        sb_q[$];
  int          n_vec = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  // 0: defaults, 1: two memory stages, 2: no forwarding, 3: 2-bit counter
  for (genvar k = 0; k < 4; k++) begin : g_dut
    localparam int MS = (k == 1) ? 2 : 1;
    localparam int FE = (k == 2) ? 0 : 1;
    localparam int CW = (k == 3) ? 2 : 32;
    logic          w_stall, w_exv;
    logic [1:0]    w_a, w_b;
    logic [CW-1:0] w_cnt;

    hazard_fwd_unit #(.REG_AW(5), .MEM_STAGES(MS), .FWD_EN(FE), .CNT_W(CW)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .id_valid     (id_in[k].valid),
      .id_rs        (id_in[k].rs),
      .id_rt        (id_in[k].rt),
      .id_use_rs    (id_in[k].use_rs),
      .id_use_rt    (id_in[k].use_rt),
      .id_reg_write (id_in[k].rw),
      .id_mem_read  (id_in[k].mr),
      .id_dest      (id_in[k].dest),
      .id_flush     (id_in[k].flush),
      .stall        (w_stall),
      .ex_valid     (w_exv),
      .ex_fwd_a_sel (w_a),
      .ex_fwd_b_sel (w_b),
      .stall_cnt    (w_cnt)
    );

    assign stall_o[k] = w_stall;
    assign exv_o[k]   = w_exv;
    assign sel_a_o[k] = w_a;
    assign sel_b_o[k] = w_b;
    assign cnt_o[k]   = 32'(w_cnt);
  end

  function automatic id_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                             input logic urt, input logic rw, input logic mr, input logic [4:0] dest);
    id_t v;
    v = '{valid: 1'b1, rs: rs, rt: rt, use_rs: urs, use_rt: urt, rw: rw, mr: mr, dest: dest, flush: 1'b0};
    return v;
  endfunction

  function automatic id_t alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return mk(rs, rt, 1'b1, 1'b1, 1'b1, 1'b0, rd);
  endfunction

  function automatic id_t addi(input logic [4:0] rt, input logic [4:0] rs);
    return mk(rs, rt, 1'b1, 1'b0, 1'b1, 1'b0, rt);
  endfunction

  function automatic id_t lw(input logic [4:0] rt, input logic [4:0] rs);
    return mk(rs, rt, 1'b1, 1'b0, 1'b1, 1'b1, rt);
  endfunction

  function automatic id_t sw(input logic [4:0] rt, input logic [4:0] rs);
    return mk(rs, rt, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
  endfunction

  task automatic expect_push(input int d, input logic st, input logic ev,
                             input logic [1:0] a, input logic [1:0] b, input logic [31:0] cnt);
    sb_q.push_back(exp_t'{d, st, ev, a, b, cnt});
  endtask

  task automatic compare(input logic obs_stall);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $error("FAIL scoreboard_empty observed=none expected=entry");
      return;
    end
    e = sb_q.pop_front();
    n_vec++;
    assert (obs_stall === e.stall) else begin
      n_bad++; $error("FAIL d%0d_stall observed=%b expected=%b", e.d, obs_stall, e.stall);
    end
    n_vec++;
    assert (exv_o[e.d] === e.exv) else begin
      n_bad++; $error("FAIL d%0d_ex_valid observed=%b expected=%b", e.d, exv_o[e.d], e.exv);
    end
    n_vec++;
    assert (sel_a_o[e.d] === e.a) else begin
      n_bad++; $error("FAIL d%0d_fwd_a observed=%0d expected=%0d", e.d, sel_a_o[e.d], e.a);
    end
    n_vec++;
    assert (sel_b_o[e.d] === e.b) else begin
      n_bad++; $error("FAIL d%0d_fwd_b observed=%0d expected=%0d", e.d, sel_b_o[e.d], e.b);
    end
    n_vec++;
    assert (cnt_o[e.d] === e.cnt) else begin
      n_bad++; $error("FAIL d%0d_stall_cnt observed=%0d expected=%0d", e.d, cnt_o[e.d], e.cnt);
    end
  endtask

  // One cycle: stall is sampled mid-cycle, registered outputs just after the edge.
  task automatic run(input int d, input id_t v, input logic st, input logic ev,
                     input logic [1:0] a, input logic [1:0] b, input logic [31:0] cnt);
    logic s;
    id_in[d] = v;
    expect_push(d, st, ev, a, b, cnt);
    @(negedge clk);
    s = stall_o[d];
    @(posedge clk);
    #1;
    compare(s);
  endtask

  initial begin
    id_t nop;
    id_t v;
    int  c_now;
    int  c_prev;
    nop = '0;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) id_in[k] = nop;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      expect_push(k, 1'b0, 1'b0, 2'd0, 2'd0, 32'd0);
      compare(stall_o[k]);
    end
    rst = 1'b0;

    // ALU -> ALU forwarding from M1
    run(0, alu(3, 1, 2), 0, 1, 0, 0, 0);
    run(0, alu(4, 3, 5), 0, 1, 1, 0, 0);
    run(0, nop,          0, 0, 0, 0, 0);

    // load-use: one bubble, then forward from WB
    run(0, lw(3, 1),     0, 1, 0, 0, 0);
    run(0, alu(4, 3, 3), 1, 0, 0, 0, 1);
    run(0, alu(4, 3, 3), 0, 1, 2, 2, 1);
    run(0, nop,          0, 0, 0, 0, 1);

    // $0 never matches; unrelated source never stalls
    run(0, addi(0, 1),   0, 1, 0, 0, 1);
    run(0, alu(2, 0, 0), 0, 1, 0, 0, 1);
    run(0, lw(3, 1),     0, 1, 0, 0, 1);
    run(0, sw(7, 7),     0, 1, 0, 0, 1);
    run(0, nop,          0, 0, 0, 0, 1);

    // flush overrides the load-use stall
    run(0, lw(3, 1),     0, 1, 0, 0, 1);
    v = alu(4, 3, 3);
    v.flush = 1'b1;
    run(0, v,            0, 0, 0, 0, 1);
    run(0, nop,          0, 0, 0, 0, 1);

    // two memory stages: two stall cycles then forward from WB (sel 3)
    run(1, lw(3, 1),     0, 1, 0, 0, 0);
    run(1, alu(4, 3, 0), 1, 0, 0, 0, 1);
    run(1, alu(4, 3, 0), 1, 0, 0, 0, 2);
    run(1, alu(4, 3, 0), 0, 1, 3, 0, 2);
    run(1, nop,          0, 0, 0, 0, 2);

    // no forwarding: wait until the producer reaches WB
    run(2, alu(3, 1, 2), 0, 1, 0, 0, 0);
    run(2, alu(5, 3, 3), 1, 0, 0, 0, 1);
    run(2, alu(5, 3, 3), 1, 0, 0, 0, 2);
    run(2, alu(5, 3, 3), 0, 1, 0, 0, 2);
    run(2, nop,          0, 0, 0, 0, 2);

    // 2-bit counter saturates at 3
    for (int i = 1; i <= 4; i++) begin
      c_now  = (i > 3) ? 3 : i;
      c_prev = (i - 1 > 3) ? 3 : i - 1;
      run(3, lw(3, 1),     0, 1, 0, 0, c_prev);
      run(3, alu(4, 3, 3), 1, 0, 0, 0, c_now);
      run(3, alu(4, 3, 3), 0, 1, 2, 2, c_now);
    end
    run(3, nop, 0, 0, 0, 0, 3);

    // reset asserted in the middle of a two-cycle stall
    run(1, lw(3, 1),     0, 1, 0, 0, 2);
    run(1, alu(4, 3, 0), 1, 0, 0, 0, 3);
    expect_push(1, 1'b1, 1'b0, 2'd0, 2'd0, 32'd3);
    compare(stall_o[1]);
    rst = 1'b1;
    #1;
    expect_push(1, 1'b0, 1'b0, 2'd0, 2'd0, 32'd0);
    compare(stall_o[1]);
    id_in[1] = nop;
    @(posedge clk);
    #1;
    rst = 1'b0;
    run(1, nop, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
Parametrised hazard-detection and forwarding controller for the 5-stage MIPS pipeline, generalised to a configurable number of pipelined data-memory stages and a selectable forwarding mode.
- Tracks every in-flight writer from EX through WB in an internal shift register.
- Decides at ID whether the decoded instruction must stall.
- Supplies registered EX-stage operand-forwarding selects.
- Keeps a saturating stall counter for performance measurement.
- Sits beside the ID/EX pipeline register. Drives IF/PC hold, the ID/EX bubble and the EX operand muxes.

Parameters:
REG_AW, 5, register address width.
MEM_STAGES, 1, number of data-memory pipeline stages (1..3). Load data is available only after the last one.
FWD_EN, 1, 1 = full forwarding; 0 = no forwarding, stall until the writer reaches WB.
CNT_W, 32, stall counter width.

Ports:
clk  in  1  clock
rst  in  1  reset
id_valid  in  1  ID holds a real instruction
id_rs  in  REG_AW  source register A
id_rt  in  REG_AW  source register B
id_use_rs  in  1  instruction reads rs
id_use_rt  in  1  instruction reads rt
id_reg_write  in  1  instruction writes a register
id_mem_read  in  1  instruction is a load
id_dest  in  REG_AW  destination register
id_flush  in  1  squash the ID instruction (branch taken)
stall  out  1  hold PC and IF/ID; insert a bubble into EX
ex_valid  out  1  EX slot holds a real instruction
ex_fwd_a_sel  out  SW  operand A source; SW = clog2(MEM_STAGES+2)
ex_fwd_b_sel  out  SW  operand B source
stall_cnt  out  CNT_W  count of stall cycles, saturating

Behaviour:
Clock and reset (already decided):
- One clock, clk.
- Reset rst is asynchronous and active-high.
- On reset: all slots invalid; stall=0, ex_valid=0, ex_fwd_a_sel=0, ex_fwd_b_sel=0, stall_cnt=0.
- Reset mid-stall clears all in-flight state. stall reads 0 from the reset edge on.

Slot tracker:
- Slots are indexed j = 0 (EX), 1..MEM_STAGES (M1..Mn), MEM_STAGES+1 (WB).
- Each slot holds {valid, wr, ld, dest}.
- Every clock the slots shift one position toward WB. The WB entry retires.
- Slot 0 loads {id_valid & ~stall & ~id_flush, id_reg_write, id_mem_read, id_dest}. Otherwise it loads a bubble (valid=0).
- The register file writes before it reads (internal bypass), so a WB-slot producer never causes a hazard.

Producer match, evaluated per source s, only when the source is used and s != 0:
- Search slots 0..MEM_STAGES for valid & wr & dest==s.
- Take the youngest match (lowest j).
- Register $0 never matches.

Stall rule:
- FWD_EN=0: any match in slots 0..MEM_STAGES is a hazard.
- FWD_EN=1: the youngest match is a hazard only if it is a load (ld=1) at j < MEM_STAGES.
- stall = id_valid & ~id_flush & (hazard on rs | hazard on rt).
- stall is combinational and re-evaluated every cycle. The number of stall cycles therefore follows from the producer's position:
  - FWD_EN=1, load: MEM_STAGES - j cycles.
  - FWD_EN=0: MEM_STAGES + 1 - j cycles.
- id_flush has priority over stall.

Forward selects:
- Registered; updated only when ID advances (~stall & ~id_flush). Otherwise they are cleared to 0 together with the bubble.
- sel = j+1 for the youngest match, meaning source M(j+1) when j+1 <= MEM_STAGES, or WB when j+1 = MEM_STAGES+1.
- sel = 0 (register file) when there is no match, the source is unused, or FWD_EN=0.
- Encoding: 0 = register file; k = ALU result of stage Mk; MEM_STAGES+1 = WB write data.

stall_cnt:
- Increments by 1 on every clock where stall=1.
- Holds at all-ones (saturates).

Decomposition:
- Package hazard_pkg holds:
  - the FWD_SRC_RF = 0 constant;
  - functions fwd_src_mem(k) and fwd_src_wb(MEM_STAGES);
  - the slot struct typedef {valid, wr, ld, dest}.
- Sub-module fwd_src_find: combinational youngest-match priority finder over the slot array. Outputs hit, j and is_load. Instantiated twice, once for rs and once for rt.

Test Plan:
1. Defaults. add $3,$1,$2 then sub $4,$3,$5 -> stall never asserts; with sub in EX, ex_fwd_a_sel=1 and ex_fwd_b_sel=0.
2. Defaults. lw $3,0($1) then add $4,$3,$3 -> stall=1 for exactly 1 cycle and ex_valid=0 that cycle; then add enters EX with both selects=2; stall_cnt=1.
3. MEM_STAGES=2. lw $3 then add $4,$3,$0 -> 2 stall cycles; then ex_fwd_a_sel=3, ex_fwd_b_sel=0; stall_cnt=2.
4. FWD_EN=0, MEM_STAGES=1. add $3 then or $5,$3,$3 -> 2 stall cycles; then selects=0.
5. addi $0,$1,4 then add $2,$0,$0 -> no stall, selects=0. lw $3 then sw using $7 only -> no stall.
6. lw $3; add uses $3 with id_flush=1 that cycle -> stall=0, bubble enters EX, stall_cnt unchanged. Separately, assert rst during a 2-cycle stall -> stall, selects and stall_cnt read 0 immediately.
